seq_multiplier: RTL

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/mult_pkg.sv | 12 +
 rtl/add_nbit.sv | 14 +
 rtl/seq_multiplier.sv | 97 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-add multiplier: FSM state encoding and default operand width.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/add_nbit.sv
// Combinational N-bit adder with carry-in and carry-out; used with N=WIDTH+1 for the multiply step.
module add_nbit #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: WIDTH+1 edges accept-to-result, product held until out_ready; one op in flight.
// SEQ_MULT_SIGNED_EN selects two's-complement operands (final step subtracts), otherwise unsigned.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [CW-1:0]        count_q;

  logic                 last_iter;
  logic                 sub;
  logic [WIDTH:0]       upper_x;
  logic [WIDTH:0]       mcand_x;
  logic [WIDTH:0]       addend;
  logic [WIDTH:0]       sum;
  logic                 unused_co;

  assign last_iter = (count_q == CW'(WIDTH - 1));

`ifdef SEQ_MULT_SIGNED_EN
  assign upper_x = {acc_q[2*WIDTH-1], acc_q[2*WIDTH-1:WIDTH]};
  assign mcand_x = {a_q[WIDTH-1], a_q};
  // The multiplier's sign bit carries weight -2^(WIDTH-1), so its partial product is subtracted.
  assign sub     = last_iter & b_q[0];
`else
  assign upper_x = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign mcand_x = {1'b0, a_q};
  assign sub     = 1'b0;
`endif

  assign addend = b_q[0] ? (sub ? ~mcand_x : mcand_x) : '0;

  add_nbit #(.N(WIDTH + 1)) u_add (
    .a    (upper_x),
    .b    (addend),
    .cin  (sub),
    .sum  (sum),
    .cout (unused_co)
  );

  assign acc_d = {sum, acc_q[WIDTH-1:1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            acc_q   <= '0;
            count_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          b_q     <= b_q >> 1;
          count_q <= count_q + 1'b1;
          if (last_iter) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q;

endmodule
